// File: rtl/ramp_checker.sv
// ramp_checker: AXI-Stream sawtooth monitor measuring period, peaks, wraps and irregular beats.
// Pipeline: input register -> wrap detection -> run/statistics update.
module ramp_checker #(
    parameter int LANES = 16,
    parameter int SW    = 16
) (
    input  logic                  S_AXIS_ACLK,
    input  logic                  S_AXIS_ARESETN,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [LANES*SW-1:0]   S_AXIS_TDATA,
    input  logic [LANES*SW/8-1:0] S_AXIS_TSTRB,
    input  logic                  S_AXIS_TLAST,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    output logic [31:0]           period,
    output logic [SW-1:0]         peak_max,
    output logic [SW-1:0]         peak_min,
    output logic                  period_valid,
    output logic                  locked,
    output logic [31:0]           wrap_count,
    output logic [15:0]           error_count,
    output logic [31:0]           beat_count
);
    localparam int DW = LANES * SW;
    localparam int LW = $clog2(LANES);
    localparam logic signed [SW-1:0] SMIN = {1'b1, {(SW-1){1'b0}}};
    localparam logic signed [SW-1:0] SMAX = {1'b0, {(SW-1){1'b1}}};

    logic                 r_tready;
    logic                 r_in_vld;
    logic [DW-1:0]        r_in_data;
    logic                 r_in_serr;
    logic                 r_s1_vld;
    logic [DW-1:0]        r_s1_data;
    logic [LANES-1:0]     r_s1_wrap;
    logic                 r_s1_serr;
    logic [SW-1:0]        r_prev;
    logic                 r_prev_ok;
    logic [31:0]          r_run_len;
    logic signed [SW-1:0] r_run_max;
    logic signed [SW-1:0] r_run_min;
    logic                 r_have;
    logic [31:0]          r_period;
    logic signed [SW-1:0] r_peak_max;
    logic signed [SW-1:0] r_peak_min;
    logic                 r_pvalid;
    logic                 r_locked;
    logic [31:0]          r_wrap_cnt;
    logic [15:0]          r_err_cnt;
    logic [31:0]          r_beat_cnt;

    logic                 w_hs;
    logic                 w_unused;
    logic [LANES-1:0]     w_wrap;
    logic signed [SW-1:0] w_lane [LANES];
    logic                 w_any;
    logic [LW-1:0]        w_first;
    logic [LW-1:0]        w_last;
    logic [LW:0]          w_cnt;
    logic signed [SW-1:0] w_pre_max;
    logic signed [SW-1:0] w_pre_min;
    logic signed [SW-1:0] w_suf_max;
    logic signed [SW-1:0] w_suf_min;
    logic [32:0]          w_sum_cand;
    logic [32:0]          w_sum_full;
    logic [31:0]          w_cand;
    logic [31:0]          w_full;
    logic                 w_err;

    assign w_hs     = S_AXIS_TVALID && r_tready;
    assign w_unused = S_AXIS_TLAST;

    // Lane 0 compares against the previous beat's last sample only once one exists.
    always_comb begin
        w_wrap = '0;
        w_wrap[0] = r_prev_ok && ($signed(r_in_data[SW-1:0]) < $signed(r_prev));
        for (int i = 1; i < LANES; i++)
            w_wrap[i] = $signed(r_in_data[SW*i +: SW]) < $signed(r_in_data[SW*(i-1) +: SW]);
    end

    always_comb begin
        for (int i = 0; i < LANES; i++)
            w_lane[i] = r_s1_data[SW*i +: SW];
    end

    // Prefix (before first wrap) closes the running period; suffix (from last wrap) opens the next.
    always_comb begin
        w_any     = |r_s1_wrap;
        w_first   = '0;
        w_last    = '0;
        w_cnt     = '0;
        w_pre_max = r_run_max;
        w_pre_min = r_run_min;
        w_suf_max = SMIN;
        w_suf_min = SMAX;
        for (int i = LANES - 1; i >= 0; i--)
            if (r_s1_wrap[i]) w_first = LW'(i);
        for (int i = 0; i < LANES; i++) begin
            if (r_s1_wrap[i]) begin
                w_last = LW'(i);
                w_cnt  = w_cnt + (LW+1)'(1);
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (!w_any || LW'(i) < w_first) begin
                if (w_lane[i] > w_pre_max) w_pre_max = w_lane[i];
                if (w_lane[i] < w_pre_min) w_pre_min = w_lane[i];
            end
            if (w_any && LW'(i) >= w_last) begin
                if (w_lane[i] > w_suf_max) w_suf_max = w_lane[i];
                if (w_lane[i] < w_suf_min) w_suf_min = w_lane[i];
            end
        end
        w_sum_cand = {1'b0, r_run_len} + 33'(w_first);
        w_sum_full = {1'b0, r_run_len} + 33'(LANES);
        w_cand     = w_sum_cand[32] ? '1 : w_sum_cand[31:0];
        w_full     = w_sum_full[32] ? '1 : w_sum_full[31:0];
        w_err      = (w_cnt > (LW+1)'(1)) || r_s1_serr;
    end

    always_ff @(posedge S_AXIS_ACLK)
        r_tready <= S_AXIS_ARESETN && enable;

    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN || clear) begin
            r_in_vld   <= 1'b0;
            r_in_data  <= '0;
            r_in_serr  <= 1'b0;
            r_s1_vld   <= 1'b0;
            r_s1_data  <= '0;
            r_s1_wrap  <= '0;
            r_s1_serr  <= 1'b0;
            r_prev     <= '0;
            r_prev_ok  <= 1'b0;
            r_run_len  <= '0;
            r_run_max  <= '0;
            r_run_min  <= '0;
            r_have     <= 1'b0;
            r_period   <= '0;
            r_peak_max <= '0;
            r_peak_min <= '0;
            r_pvalid   <= 1'b0;
            r_locked   <= 1'b0;
            r_wrap_cnt <= '0;
            r_err_cnt  <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_in_vld <= w_hs;
            if (w_hs) begin
                r_in_data <= S_AXIS_TDATA;
                r_in_serr <= S_AXIS_TSTRB != '1;
            end
            r_s1_vld <= r_in_vld;
            if (r_in_vld) begin
                r_s1_data  <= r_in_data;
                r_s1_wrap  <= w_wrap;
                r_s1_serr  <= r_in_serr;
                r_prev     <= r_in_data[DW-1 -: SW];
                r_prev_ok  <= 1'b1;
                r_beat_cnt <= r_beat_cnt + 32'd1;
            end
            r_pvalid <= 1'b0;
            if (r_s1_vld) begin
                if (!w_any) begin
                    r_run_len <= w_full;
                    r_run_max <= w_pre_max;
                    r_run_min <= w_pre_min;
                end else begin
                    if (r_have) begin
                        r_period   <= w_cand;
                        r_peak_max <= w_pre_max;
                        r_peak_min <= w_pre_min;
                        r_pvalid   <= 1'b1;
                        r_locked   <= w_cand == r_period;
                    end
                    r_have     <= 1'b1;
                    r_run_len  <= 32'(LANES) - 32'(w_last);
                    r_run_max  <= w_suf_max;
                    r_run_min  <= w_suf_min;
                    r_wrap_cnt <= r_wrap_cnt + 32'(w_cnt);
                end
                if (w_err) begin
                    r_err_cnt <= (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + 16'd1;
                    r_locked  <= 1'b0;
                end
            end
        end
    end

    assign S_AXIS_TREADY = r_tready;
    assign period        = r_period;
    assign peak_max      = r_peak_max;
    assign peak_min      = r_peak_min;
    assign period_valid  = r_pvalid;
    assign locked        = r_locked;
    assign wrap_count    = r_wrap_cnt;
    assign error_count   = r_err_cnt;
    assign beat_count    = r_beat_cnt;
endmodule
